// File: rtl/lutram_fifo_pkg.sv
// Shared types and pointer helpers for the distributed-RAM FWFT FIFO.
// Pointers carry one wrap bit above the RAM index; helpers work for any index width up to MAX_ADDR_WIDTH.
package lutram_fifo_pkg;

  localparam int unsigned FIFO_ADDR_WIDTH = 4;
  localparam int unsigned MAX_ADDR_WIDTH  = 15;

  typedef logic [MAX_ADDR_WIDTH:0] ptr_t;
  typedef logic [MAX_ADDR_WIDTH:0] count_t;

  function automatic logic ptr_empty(input ptr_t wr, input ptr_t rd);
    return wr == rd;
  endfunction

  // Full when the index bits match and only the wrap bit (bit aw) differs.
  function automatic logic ptr_full(input ptr_t wr, input ptr_t rd,
                                    input int unsigned aw = FIFO_ADDR_WIDTH);
    ptr_t wrap_only;
    wrap_only = ptr_t'(1) << aw;
    return (wr ^ rd) == wrap_only;
  endfunction

endpackage

// File: rtl/lutram_fifo_ram.sv
// Dual-port distributed RAM: port 1 writes (byte strobed) and reads, port 2 reads only.
// READ_LATENCY 0 gives asynchronous reads; any other value registers both read ports.
module LUTRAM_DualPort #(
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned BYTE_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 0
) (
  input  logic                           clk,
  input  logic                           en_1,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] strobe_1,
  input  logic [ADDR_WIDTH-1:0]          addr_1,
  input  logic [DATA_WIDTH-1:0]          wdata_1,
  output logic [DATA_WIDTH-1:0]          rdata_1,
  input  logic                           en_2,
  input  logic [ADDR_WIDTH-1:0]          addr_2,
  output logic [DATA_WIDTH-1:0]          rdata_2
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // NOTE: the storage array has no reset branch; resetting it would stop it
  // mapping onto distributed RAM, and its contents are never trusted before a write.
  always_ff @(posedge clk) begin
    if (en_1) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (strobe_1[b]) begin
          mem[addr_1][b*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_1[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  if (READ_LATENCY == 0) begin : g_async_read
    assign rdata_1 = mem[addr_1];
    assign rdata_2 = en_2 ? mem[addr_2] : '0;
  end else begin : g_sync_read
    logic [DATA_WIDTH-1:0] rdata_1_q;
    logic [DATA_WIDTH-1:0] rdata_2_q;

    always_ff @(posedge clk) begin
      if (en_1) rdata_1_q <= mem[addr_1];
      if (en_2) rdata_2_q <= mem[addr_2];
    end

    assign rdata_1 = rdata_1_q;
    assign rdata_2 = rdata_2_q;
  end

endmodule

// File: rtl/lutram_fifo.sv
// First-word-fall-through FIFO over a distributed RAM: pointers, occupancy and flags live here,
// data goes straight from the producer into the RAM and from the RAM's async port to the consumer.
module lutram_fifo
  import lutram_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = FIFO_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned AFULL_LEVEL = (1 << ADDR_WIDTH) - 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full
);

  typedef logic [ADDR_WIDTH:0] fifo_ptr_t;

  localparam fifo_ptr_t PTR_ONE   = fifo_ptr_t'(1);
  localparam fifo_ptr_t AFULL_CNT = fifo_ptr_t'(AFULL_LEVEL);

  fifo_ptr_t wr_ptr_q, wr_ptr_d;
  fifo_ptr_t rd_ptr_q, rd_ptr_d;
  fifo_ptr_t count_q,  count_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic [DATA_WIDTH-1:0] unused_rdata_1;

  // Flags come only from registered pointers, so no input reaches them combinationally.
  assign full        = ptr_full(ptr_t'(wr_ptr_q), ptr_t'(rd_ptr_q), ADDR_WIDTH);
  assign empty       = ptr_empty(ptr_t'(wr_ptr_q), ptr_t'(rd_ptr_q));
  assign in_ready    = !full;
  assign out_valid   = !empty;
  assign almost_full = count_q >= AFULL_CNT;
  assign count       = count_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // NOTE: every variable gets its hold value before any branch, so no path
  // through this block leaves one unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count_d = count_q + PTR_ONE;
        2'b01:   count_d = count_q - PTR_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  LUTRAM_DualPort #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .BYTE_WIDTH   (DATA_WIDTH),
    .READ_LATENCY (0)
  ) u_ram (
    .clk      (clk),
    .en_1     (push),
    .strobe_1 (1'b1),
    .addr_1   (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_1  (in_data),
    .rdata_1  (unused_rdata_1),
    .en_2     (1'b1),
    .addr_2   (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_2  (out_data)
  );

endmodule
